pe_window_gen: RTL and testbench

PE_WINDOW_GEN -- requirements
Module: pe_window_gen

---
 rtl/pe_window_gen_pkg.sv | 18 +
 rtl/pe_window_gen_line_buf.sv | 28 ++
 rtl/pe_window_gen.sv | 121 ++++++++++++
 tb/tb_pe_window_gen.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pe_window_gen_pkg.sv
// Shared PE datapath constants: pixel/channel widths and the packed 2x3x3 window layout.
// Also used by the PE datapath so both sides agree on the window byte order.
package pe_window_gen_pkg;

   localparam int BIT_W      = 8;
   localparam int N_CH       = 2;
   localparam int WIN_K      = 3;
   localparam int PIX_W      = BIT_W * N_CH;
   localparam int PE_IMAGE_W = 144;

   typedef logic [BIT_W-1:0] pel_t;

   // MSB of a window element; ch0 r0c0 occupies the top byte, ch1 r2c2 the bottom byte.
   function automatic int byte_msb(input int ch, input int r, input int c);
      return PE_IMAGE_W - 1 - BIT_W * (ch * WIN_K * WIN_K + r * WIN_K + c);
   endfunction

endpackage

// File: rtl/pe_window_gen_line_buf.sv
// Single-port delay line, one entry per image column, read-before-write.
// The read data at an address is the value written there one row earlier.
module pe_line_buf
   import pe_window_gen_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = PIX_W,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             en,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   assign rd_data = mem[addr];

   // Contents are never reset; stale data is masked by the row guard in the top.
   always_ff @(posedge clk) begin
      if (en) begin
         mem[addr] <= wr_data;
      end
   end

endmodule

// File: rtl/pe_window_gen.sv
// Streams raster pixels in and emits registered 2x3x3 windows (valid convolution, no padding)
// with a ready/valid handshake on both sides.
module pe_window_gen
   import pe_window_gen_pkg::*;
#(
   parameter int IMG_W = 8,
   parameter int IMG_H = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_pix_valid,
   input  logic [PIX_W-1:0]      i_pix_data,
   output logic                  o_pix_ready,
   output logic                  o_win_valid,
   output logic [PE_IMAGE_W-1:0] o_win_data,
   input  logic                  i_win_ready,
   output logic                  o_frame_done
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);

   logic [CW-1:0]         col;
   logic [RW-1:0]         row;
   logic                  pix_hs;
   logic                  win_hs;
   logic                  qualify;
   logic                  last_col;
   logic                  last_row;
   logic                  win_last;
   logic [PIX_W-1:0]      prev_row_pix;
   logic [PIX_W-1:0]      old_row_pix;
   pel_t                  win_q [N_CH][WIN_K][WIN_K];
   pel_t                  win_d [N_CH][WIN_K][WIN_K];
   logic [PE_IMAGE_W-1:0] win_flat;

   // A new pixel may enter only when the output slot is empty or being drained this cycle.
   assign o_pix_ready = !o_win_valid || i_win_ready;
   assign pix_hs      = i_pix_valid && o_pix_ready;
   assign win_hs      = o_win_valid && i_win_ready;
   assign last_col    = (col == CW'(IMG_W - 1));
   assign last_row    = (row == RW'(IMG_H - 1));
   assign qualify     = pix_hs && (row >= RW'(2)) && (col >= CW'(2));

   pe_line_buf #(
      .DEPTH   (IMG_W),
      .WIDTH   (PIX_W)
   ) u_lb_prev (
      .clk     (i_clk),
      .en      (pix_hs),
      .addr    (col),
      .wr_data (i_pix_data),
      .rd_data (prev_row_pix)
   );

   pe_line_buf #(
      .DEPTH   (IMG_W),
      .WIDTH   (PIX_W)
   ) u_lb_old (
      .clk     (i_clk),
      .en      (pix_hs),
      .addr    (col),
      .wr_data (prev_row_pix),
      .rd_data (old_row_pix)
   );

   always_comb begin
      win_d    = win_q;
      win_flat = '0;
      for (int ch = 0; ch < N_CH; ch++) begin
         for (int r = 0; r < WIN_K; r++) begin
            win_d[ch][r][0] = win_q[ch][r][1];
            win_d[ch][r][1] = win_q[ch][r][2];
         end
         win_d[ch][0][2] = old_row_pix[PIX_W-1-ch*BIT_W -: BIT_W];
         win_d[ch][1][2] = prev_row_pix[PIX_W-1-ch*BIT_W -: BIT_W];
         win_d[ch][2][2] = i_pix_data[PIX_W-1-ch*BIT_W -: BIT_W];
         for (int r = 0; r < WIN_K; r++) begin
            for (int c = 0; c < WIN_K; c++) begin
               win_flat[byte_msb(ch, r, c) -: BIT_W] = win_d[ch][r][c];
            end
         end
      end
   end

   // Shift window tracks every accepted pixel; it is only published when it covers valid rows/cols.
   always_ff @(posedge i_clk) begin
      if (pix_hs) begin
         win_q <= win_d;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         col          <= '0;
         row          <= '0;
         o_win_valid  <= 1'b0;
         o_win_data   <= '0;
         o_frame_done <= 1'b0;
         win_last     <= 1'b0;
      end else begin
         o_frame_done <= win_hs && win_last;
         if (pix_hs) begin
            if (last_col) begin
               col <= '0;
               row <= last_row ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
         if (qualify) begin
            o_win_valid <= 1'b1;
            o_win_data  <= win_flat;
            win_last    <= last_col && last_row;
         end else if (win_hs) begin
            o_win_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pe_window_gen.sv
// Self-checking bench for pe_window_gen: directed 4x4 scenarios plus a randomized 8x6 run,
// all compared against a frame-array window model.
module tb_pe_window_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         a_pv, a_wr, a_pr, a_wv, a_fd;
   logic [15:0]  a_pd;
   logic [143:0] a_wd;
   logic         b_pv, b_wr, b_pr, b_wv, b_fd;
   logic [15:0]  b_pd;
   logic [143:0] b_wd;

   pe_window_gen #(.IMG_W(4), .IMG_H(4)) dut_a (
      .i_clk(clk), .i_rst(rst), .i_pix_valid(a_pv), .i_pix_data(a_pd), .o_pix_ready(a_pr),
      .o_win_valid(a_wv), .o_win_data(a_wd), .i_win_ready(a_wr), .o_frame_done(a_fd));

   pe_window_gen #(.IMG_W(8), .IMG_H(6)) dut_b (
      .i_clk(clk), .i_rst(rst), .i_pix_valid(b_pv), .i_pix_data(b_pd), .o_pix_ready(b_pr),
      .o_win_valid(b_wv), .o_win_data(b_wd), .i_win_ready(b_wr), .o_frame_done(b_fd));

   int           n_tests = 0;
   int           n_fail  = 0;
   bit           sel;
   int           img_w, img_h;
   logic [15:0]  img [48];
   int           pix_cnt, n_pix, n_win, n_done;
   logic [144:0] exp_q [$];
   logic         fd_exp;
   logic [143:0] win_log [$];
   logic [143:0] saved_log [$];
   logic         s_pr, s_wv, s_fd, s_acc;
   logic [143:0] s_wd;

   task automatic checkOutput(input string tag, input logic [143:0] obs, input logic [143:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkInt(input string tag, input int obs, input int exp);
      checkOutput(tag, 144'(unsigned'(obs)), 144'(unsigned'(exp)));
   endtask

   function automatic logic [15:0] pix16(input int p);
      logic [7:0] v;
      v = 8'(p);
      return {v, v + 8'h80};
   endfunction

   // Window for the pixel at (r,c): rows r-2..r, cols c-2..c of the current frame, ch0 block first.
   function automatic logic [143:0] model_window(input int r, input int c);
      logic [143:0] w;
      logic [15:0]  p;
      w = '0;
      for (int dr = 0; dr < 3; dr++) begin
         for (int dc = 0; dc < 3; dc++) begin
            p = img[(r - 2 + dr) * img_w + (c - 2 + dc)];
            w[143 - 8 * (dr * 3 + dc) -: 8]     = p[15:8];
            w[143 - 8 * (9 + dr * 3 + dc) -: 8] = p[7:0];
         end
      end
      return w;
   endfunction

   task automatic readOut();
      if (sel == 1'b0) begin
         s_pr = a_pr; s_wv = a_wv; s_wd = a_wd; s_fd = a_fd;
      end else begin
         s_pr = b_pr; s_wv = b_wv; s_wd = b_wd; s_fd = b_fd;
      end
   endtask

   // One clock cycle: drive at the falling edge, check just after, then advance the model.
   task automatic applyStimulus(input logic pv, input logic [15:0] pd, input logic wr);
      logic exp_valid;
      int   r, c;
      @(negedge clk);
      if (sel == 1'b0) begin
         a_pv = pv; a_pd = pd; a_wr = wr;
      end else begin
         b_pv = pv; b_pd = pd; b_wr = wr;
      end
      #1;
      readOut();
      exp_valid = (exp_q.size() != 0);
      checkOutput("pix_ready", {143'b0, s_pr}, {143'b0, (!exp_valid || wr)});
      checkOutput("win_valid", {143'b0, s_wv}, {143'b0, exp_valid});
      if (exp_valid) checkOutput("win_data", s_wd, exp_q[0][143:0]);
      checkOutput("frame_done", {143'b0, s_fd}, {143'b0, fd_exp});
      if (s_fd) n_done++;
      fd_exp = 1'b0;
      if (exp_valid && wr) begin
         fd_exp = exp_q[0][144];
         win_log.push_back(s_wd);
         exp_q.delete(0);
         n_win++;
      end
      s_acc = pv && (!exp_valid || wr);
      if (s_acc) begin
         r = pix_cnt / img_w;
         c = pix_cnt % img_w;
         img[pix_cnt] = pd;
         if (r >= 2 && c >= 2) exp_q.push_back({(pix_cnt == img_w * img_h - 1), model_window(r, c)});
         pix_cnt = (pix_cnt + 1) % (img_w * img_h);
         n_pix++;
      end
   endtask

   task automatic sendPixel(input logic [15:0] pd, input logic wr);
      int tries;
      tries = 0;
      do begin
         applyStimulus(1'b1, pd, wr);
         tries++;
      end while (!s_acc && tries < 50);
      checkOutput("pix_accept", {143'b0, s_acc}, {143'b0, 1'b1});
   endtask

   task automatic doReset(input bit which, input int w, input int h);
      @(negedge clk);
      a_pv = 1'b0; b_pv = 1'b0; a_wr = 1'b0; b_wr = 1'b0;
      rst = 1'b1;
      sel = which;
      img_w = w;
      img_h = h;
      #1;
      readOut();
      checkOutput("rst_win_valid", {143'b0, s_wv}, '0);
      checkOutput("rst_frame_done", {143'b0, s_fd}, '0);
      checkOutput("rst_win_data", s_wd, '0);
      exp_q.delete();
      win_log.delete();
      pix_cnt = 0; n_pix = 0; n_win = 0; n_done = 0;
      fd_exp = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic pv_r;
      rst = 1'b0;
      a_pv = 1'b0; a_wr = 1'b0; a_pd = '0;
      b_pv = 1'b0; b_wr = 1'b0; b_pd = '0;

      // Baseline 4x4 frame, consumer always ready.
      doReset(1'b0, 4, 4);
      for (int p = 0; p < 16; p++) sendPixel(pix16(p), 1'b1);
      repeat (3) applyStimulus(1'b0, 16'h0, 1'b1);
      checkInt("A_windows", n_win, 4);
      checkInt("A_frame_done", n_done, 1);
      checkOutput("A_w0_ch0_r0c0", 144'(win_log[0][143:136]), 144'(8'h00));
      checkOutput("A_w0_ch0_r2c2", 144'(win_log[0][79:72]), 144'(8'h0A));
      checkOutput("A_w0_ch1_r0c0", 144'(win_log[0][71:64]), 144'(8'h80));
      checkOutput("A_w0_ch1_r2c2", 144'(win_log[0][7:0]), 144'(8'h8A));
      saved_log = win_log;

      // Consumer stalls for five cycles while window 1 is pending.
      doReset(1'b0, 4, 4);
      for (int p = 0; p < 12; p++) sendPixel(pix16(p), 1'b1);
      repeat (5) begin
         applyStimulus(1'b1, pix16(12), 1'b0);
         checkOutput("B_stall_ready", {143'b0, s_pr}, '0);
         checkOutput("B_stall_valid", {143'b0, s_wv}, {143'b0, 1'b1});
         checkOutput("B_w1_ch0_r0c0", 144'(s_wd[143:136]), 144'(8'h01));
      end
      for (int p = 12; p < 16; p++) sendPixel(pix16(p), 1'b1);
      repeat (3) applyStimulus(1'b0, 16'h0, 1'b1);
      checkInt("B_windows", n_win, 4);
      for (int i = 0; i < 4; i++) checkOutput("B_same_as_A", win_log[i], saved_log[i]);

      // Two back-to-back frames with distinct pixel values.
      doReset(1'b0, 4, 4);
      for (int p = 0; p < 32; p++) sendPixel((p < 16) ? pix16(p) : pix16(p + 48), 1'b1);
      repeat (3) applyStimulus(1'b0, 16'h0, 1'b1);
      checkInt("C_windows", n_win, 8);
      checkInt("C_frame_done", n_done, 2);
      checkOutput("C_f2w0_ch0_r0c0", 144'(win_log[4][143:136]), 144'(8'h40));
      checkOutput("C_f2w0_ch1_r2c2", 144'(win_log[4][7:0]), 144'(8'hCA));

      // Reset mid-frame, then a clean frame must reproduce the baseline windows.
      doReset(1'b0, 4, 4);
      for (int p = 0; p < 8; p++) sendPixel(pix16(p), 1'b1);
      doReset(1'b0, 4, 4);
      for (int p = 0; p < 16; p++) sendPixel(pix16(p), 1'b1);
      repeat (3) applyStimulus(1'b0, 16'h0, 1'b1);
      checkInt("D_windows", n_win, 4);
      for (int i = 0; i < 4; i++) checkOutput("D_same_as_A", win_log[i], saved_log[i]);

      // Randomized handshakes on an 8x6 frame.
      doReset(1'b1, 8, 6);
      for (int cyc = 0; cyc < 4000 && !(n_win == 24 && n_pix == 48); cyc++) begin
         pv_r = (n_pix < 48) && ($urandom_range(0, 3) != 0);
         applyStimulus(pv_r, 16'($urandom), ($urandom_range(0, 2) != 0));
      end
      repeat (3) applyStimulus(1'b0, 16'h0, 1'b1);
      checkInt("E_pixels", n_pix, 48);
      checkInt("E_windows", n_win, 24);
      checkInt("E_frame_done", n_done, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
